// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with majority voting and FWFT receive FIFO
//
// Purpose: receives asynchronous serial frames of configurable format, votes
// each bit from three mid-bit samples, rejects short start glitches, tags each
// byte with parity/framing status, handles line breaks and queues the results
// in a first-word-fall-through FIFO with sticky overrun detection.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   rx_i          serial line, idle high, asynchronous to clk_i
//   rd_en_i       pop the head entry (ignored while empty)
//   clr_ovr_i     clear the overrun flag
//   byte_o        head-entry data, LSB first received
//   parity_err_o  head-entry parity mismatch
//   frame_err_o   head-entry stop bit sampled low
//   rx_empty_o    FIFO holds no entries
//   rx_full_o     FIFO holds FIFO_DEPTH entries
//   overrun_o     sticky: a frame was dropped because the FIFO was full

module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 rd_en_i,
  input  logic                 clr_ovr_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 rx_empty_o,
  output logic                 rx_full_o,
  output logic                 overrun_o
);

  localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int EW  = DATA_BITS + 2;

  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_e;

  // Baud tick generator and input synchroniser
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  assign tick       = (tick_cnt_q == T_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_cnt_q <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  // Receive FSM
  state_e               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [1:0]           smp_q, smp_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 mid, maj, last_stop, push;
  logic [EW-1:0]        push_data;

  // The third vote is taken live at the mid tick, so the decision needs no extra cycle.
  assign mid       = tick && (s_q == S_HI);
  assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);
  assign last_stop = (STOP_BITS == 1) || stop_cnt_q;
  assign push_data = {ferr_q | ~maj, perr_q, shift_q};

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    smp_d      = smp_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_cnt_d = stop_cnt_q;
    push       = 1'b0;

    if (state_q != S_IDLE && tick) begin
      s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      if (s_q == S_LO)  smp_d[0] = rx_sync_q;
      if (s_q == S_MID) smp_d[1] = rx_sync_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = S_START;
          s_d        = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (mid) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else                                 bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_PAR: begin
        if (mid) begin
          perr_d  = (((^shift_q) ^ maj) != (PARITY == 1));
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (!maj) ferr_d = 1'b1;
          if (last_stop) begin
            push    = 1'b1;
            // Resync immediately rather than waiting out the stop bit.
            state_d = maj ? S_IDLE : S_BRK;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      S_BRK: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      s_q        <= '0;
      smp_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      smp_q      <= smp_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Receive FIFO (first-word fall-through)
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          ovr_q, ovr_d;
  logic          empty, full, do_pop, do_push;
  logic [AW-1:0] head_idx;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = rd_en_i && !empty;
  assign do_push = push && (!full || do_pop);
  assign wptr_d  = do_push ? wptr_q + PW'(1) : wptr_q;
  assign rptr_d  = do_pop  ? rptr_q + PW'(1) : rptr_q;
  assign ovr_d   = (push && full && !do_pop) ? 1'b1 : (clr_ovr_i ? 1'b0 : ovr_q);

  // When empty, show the most recently popped slot so outputs hold their last value.
  assign head_idx = empty ? rptr_q[AW-1:0] - AW'(1) : rptr_q[AW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign {frame_err_o, parity_err_o, byte_o} = mem_q[head_idx];
  assign rx_empty_o = empty;
  assign rx_full_o  = full;
  assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 and 8E1 instances)

module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 15_625;
  localparam int DIV      = 4;         // round(1e6 / (15625*16))
  localparam int BT       = DIV * 16;  // clocks per bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rd0 = 1'b0, clr0 = 1'b0;
  logic rx1 = 1'b1, rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] byte0, byte1;
  logic pe0, fe0, empty0, full0, ovr0;
  logic pe1, fe1, empty1, full1, ovr1;

  int nvec = 0;
  int nerr = 0;
  int n    = 0;   // clock edges since reset release

  logic [9:0] exp0[$];
  logic [9:0] exp1[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx0), .rd_en_i(rd0), .clr_ovr_i(clr0),
    .byte_o(byte0), .parity_err_o(pe0), .frame_err_o(fe0),
    .rx_empty_o(empty0), .rx_full_o(full0), .overrun_o(ovr0));

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dutp (
    .clk_i(clk), .rst_i(rst), .rx_i(rx1), .rd_en_i(rd1), .clr_ovr_i(clr1),
    .byte_o(byte1), .parity_err_o(pe1), .frame_err_o(fe1),
    .rx_empty_o(empty1), .rx_full_o(full1), .overrun_o(ovr1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rd0 && !empty0) begin
      if (exp0.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL pop0_unexpected: got %0h expected no entry", {fe0, pe0, byte0});
      end else check("pop0_head", {22'd0, fe0, pe0, byte0}, {22'd0, exp0.pop_front()});
    end
    if (!rst && rd1 && !empty1) begin
      if (exp1.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL pop1_unexpected: got %0h expected no entry", {fe1, pe1, byte1});
      end else check("pop1_head", {22'd0, fe1, pe1, byte1}, {22'd0, exp1.pop_front()});
    end
  end

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stop);
    drive(which, 1'b0); wait_cycles(BT);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]); wait_cycles(BT);
    end
    if (has_par) begin
      drive(which, pbit); wait_cycles(BT);
    end
    drive(which, stop); wait_cycles(BT);
    drive(which, 1'b1); wait_cycles(2 * BT);
  endtask

  task automatic pop(input int which);
    int k = 0;
    while (((which == 0) ? empty0 : empty1) && k < 4 * BT) begin
      wait_cycles(1); k++;
    end
    if ((which == 0) ? empty0 : empty1) begin
      nvec++; nerr++;
      $display("FAIL pop_wait: got rx_empty=1 expected an entry within %0d clks", 4 * BT);
    end else begin
      if (which == 0) rd0 = 1'b1; else rd1 = 1'b1;
      wait_cycles(1);
      rd0 = 1'b0; rd1 = 1'b0;
    end
  endtask

  // First push lands one clock after a mid-sample tick, i.e. edge count divisible by DIV.
  task automatic watch_empty_fall();
    bit seen = 0;
    for (int k = 0; k < 12 * BT; k++) begin
      @(negedge clk);
      if (!empty0) begin
        seen = 1;
        break;
      end
    end
    check("t1_empty_fall_seen", {31'd0, seen}, 32'd1);
    if (seen) check("t1_empty_fall_phase", n % DIV, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte"},  {24'd0, byte0}, 32'h00);
    check({tag, "_perr"},  {31'd0, pe0},   32'd0);
    check({tag, "_ferr"},  {31'd0, fe0},   32'd0);
    check({tag, "_empty"}, {31'd0, empty0}, 32'd1);
    check({tag, "_full"},  {31'd0, full0}, 32'd0);
    check({tag, "_ovr"},   {31'd0, ovr0},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wait_cycles(3);
    check_reset_vals("rst");
    check("rst_empty1", {31'd0, empty1}, 32'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    wait_cycles(5);

    // 1: 8N1 frame 0xF2
    exp0.push_back({2'b00, 8'hF2});
    fork
      send_frame(0, 8'hF2, 0, 0, 1);
      watch_empty_fall();
    join
    check("t1_byte_head", {24'd0, byte0}, 32'hF2);
    pop(0);
    check("t1_empty_after_pop", {31'd0, empty0}, 32'd1);

    // 2: even parity instance
    exp1.push_back({2'b01, 8'h03});
    send_frame(1, 8'h03, 1, 1, 1);
    pop(1);
    exp1.push_back({2'b00, 8'h03});
    send_frame(1, 8'h03, 1, 0, 1);
    pop(1);

    // 3: framing error, break, recovery
    exp0.push_back({2'b10, 8'h55});
    send_frame(0, 8'h55, 0, 0, 0);
    pop(0);
    exp0.push_back({2'b10, 8'h00});
    drive(0, 1'b0); wait_cycles(30 * BT);
    drive(0, 1'b1); wait_cycles(2 * BT);
    pop(0);
    check("t3_single_break_entry", {31'd0, empty0}, 32'd1);
    exp0.push_back({2'b00, 8'hA5});
    send_frame(0, 8'hA5, 0, 0, 1);
    pop(0);

    // 4: start glitch of 4 ticks
    drive(0, 1'b0); wait_cycles(4 * DIV);
    drive(0, 1'b1); wait_cycles(3 * BT);
    check("t4_glitch_no_entry", {31'd0, empty0}, 32'd1);
    exp0.push_back({2'b00, 8'h3C});
    send_frame(0, 8'h3C, 0, 0, 1);
    pop(0);

    // 5: fill, overrun, drain, clear
    for (int i = 0; i < 4; i++) begin
      exp0.push_back({2'b00, 8'h11 + 8'(i)});
      send_frame(0, 8'h11 + 8'(i), 0, 0, 1);
    end
    check("t5_full", {31'd0, full0}, 32'd1);
    check("t5_no_ovr_yet", {31'd0, ovr0}, 32'd0);
    send_frame(0, 8'h15, 0, 0, 1);
    check("t5_ovr", {31'd0, ovr0}, 32'd1);
    check("t5_head_kept", {24'd0, byte0}, 32'h11);
    for (int i = 0; i < 4; i++) pop(0);
    check("t5_drained", {31'd0, empty0}, 32'd1);
    check("t5_ovr_sticky", {31'd0, ovr0}, 32'd1);
    clr0 = 1'b1; wait_cycles(1); clr0 = 1'b0;
    check("t5_ovr_clr", {31'd0, ovr0}, 32'd0);

    // 6: reset mid-frame with a queued entry
    exp0.push_back({2'b00, 8'h42});
    send_frame(0, 8'h42, 0, 0, 1);
    check("t6_preload", {31'd0, empty0}, 32'd0);
    drive(0, 1'b0); wait_cycles(BT);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'(8'h99 >> i)); wait_cycles(BT);
    end
    wait_cycles(BT / 2);
    rst = 1'b1;
    drive(0, 1'b1);
    exp0.delete();
    wait_cycles(3);
    check_reset_vals("t6_in_rst");
    @(negedge clk); #1;
    rst = 1'b0;
    wait_cycles(12 * BT);
    check_reset_vals("t6_after");
    exp0.push_back({2'b00, 8'h7E});
    send_frame(0, 8'h7E, 0, 0, 1);
    check("t6_byte", {24'd0, byte0}, 32'h7E);
    pop(0);

    wait_cycles(4);
    check("sb0_drained", exp0.size(), 32'd0);
    check("sb1_drained", exp1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
